// File: rtl/sort_mem_slave_if.sv
// AR/R and AW/W channel bundle between sort_circuit (master) and its memory slave.
// A transfer happens on a rising clock edge where valid && ready are both high.
interface sort_mem_slave_if #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32
);
    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_WDTH-1:0] ar_address;
    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_WDTH-1:0] r_data;
    logic                 aw_valid;
    logic                 aw_ready;
    logic [ADDR_WDTH-1:0] aw_address;
    logic                 w_valid;
    logic                 w_ready;
    logic [DATA_WDTH-1:0] w_data;

    modport master (
        output ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data,
        input  ar_ready, r_valid, r_data, aw_ready, w_ready
    );

    modport slave (
        input  ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data,
        output ar_ready, r_valid, r_data, aw_ready, w_ready
    );
endinterface

// File: rtl/sort_mem_slave.sv
// Word-addressed memory serving sort_circuit: latency-programmable reads,
// independently buffered write address/data, and a host preload/readback port.
module sort_mem_slave #(
    parameter int ADDR_WDTH  = 4,
    parameter int DATA_WDTH  = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sort_mem_slave_if.slave      bus,
    input  logic                 host_we,
    input  logic [ADDR_WDTH-1:0] host_addr,
    input  logic [DATA_WDTH-1:0] host_wdata,
    output logic [DATA_WDTH-1:0] host_rdata,
    output logic                 busy,
    output logic [1:0]           rd_state
);
    localparam int DEPTH = 1 << ADDR_WDTH;
    localparam logic [3:0] WAIT_LOAD = (RD_LATENCY >= 2) ? 4'(RD_LATENCY - 2) : 4'd0;

    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
        $error("sort_mem_slave: RD_LATENCY=%0d outside 1..15", RD_LATENCY);
    end

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    logic [DATA_WDTH-1:0] mem [DEPTH];

    rd_state_t            state, next_state;
    logic [3:0]           lat_cnt;
    logic [ADDR_WDTH-1:0] rd_addr;
    logic [ADDR_WDTH-1:0] cap_addr;
    logic                 capture;

    logic                 aw_full, w_full;
    logic [ADDR_WDTH-1:0] aw_buf;
    logic [DATA_WDTH-1:0] w_buf;
    logic                 aw_hs, w_hs, commit;

    always_comb begin
        next_state   = state;
        bus.ar_ready = 1'b0;
        bus.r_valid  = 1'b0;
        capture      = 1'b0;
        cap_addr     = rd_addr;
        case (state)
            R_IDLE: begin
                bus.ar_ready = 1'b1;
                if (bus.ar_valid) begin
                    if (RD_LATENCY == 1) begin
                        capture    = 1'b1;
                        cap_addr   = bus.ar_address;
                        next_state = R_RESP;
                    end else begin
                        next_state = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (lat_cnt == 4'd0) begin
                    capture    = 1'b1;
                    next_state = R_RESP;
                end
            end
            R_RESP: begin
                bus.r_valid = 1'b1;
                if (bus.r_ready) next_state = R_IDLE;
            end
            default: next_state = R_IDLE;
        endcase
    end

    // r_data samples mem before any same-edge commit lands: read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= R_IDLE;
            lat_cnt    <= 4'd0;
            rd_addr    <= '0;
            bus.r_data <= '0;
        end else begin
            state <= next_state;
            if (state == R_IDLE && bus.ar_valid) begin
                rd_addr <= bus.ar_address;
                lat_cnt <= WAIT_LOAD;
            end else if (state == R_WAIT && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (capture) bus.r_data <= mem[cap_addr];
        end
    end

    assign bus.aw_ready = !aw_full;
    assign bus.w_ready  = !w_full;
    assign aw_hs        = bus.aw_valid && !aw_full;
    assign w_hs         = bus.w_valid && !w_full;
    assign commit       = aw_full && w_full;

    // Both buffers are full only on a commit edge, so no new handshake can coincide with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_buf  <= '0;
            w_buf   <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_buf  <= bus.aw_address;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_buf  <= bus.w_data;
            end
        end
    end

    // Storage has no reset so the array survives a mid-sort reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[aw_buf] <= w_buf;
        end else if (host_we && !busy) begin
            mem[host_addr] <= host_wdata;
        end
    end

    assign host_rdata = mem[host_addr];
    assign busy       = (state != R_IDLE) || aw_full || w_full;
    assign rd_state   = state;
endmodule

// File: tb/tb_sort_mem_slave.sv
// Self-checking bench for sort_mem_slave: one instance at read latency 1, one at latency 4.
module tb_sort_mem_slave;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sort_mem_slave_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW)) bus_a ();
    sort_mem_slave_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW)) bus_b ();

    logic          host_we_a, host_we_b;
    logic [AW-1:0] host_addr_a, host_addr_b;
    logic [DW-1:0] host_wdata_a, host_wdata_b;
    logic [DW-1:0] host_rdata_a, host_rdata_b;
    logic          busy_a, busy_b;
    logic [1:0]    state_a, state_b;

    sort_mem_slave #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .host_we(host_we_a), .host_addr(host_addr_a), .host_wdata(host_wdata_a),
        .host_rdata(host_rdata_a), .busy(busy_a), .rd_state(state_a)
    );

    sort_mem_slave #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RD_LATENCY(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .host_we(host_we_b), .host_addr(host_addr_b), .host_wdata(host_wdata_b),
        .host_rdata(host_rdata_b), .busy(busy_b), .rd_state(state_b)
    );

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] ref_a [16];
    logic [DW-1:0] ref_b [16];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            via_bus;
        int            gap;
        bit            w_first;
        int            hold;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit was_busy;
        was_busy = busy_a;
        host_we_a = 1'b1; host_addr_a = addr; host_wdata_a = data;
        tick();
        host_we_a = 1'b0;
        if (!was_busy) ref_a[addr] = data;
    endtask

    task automatic host_write_b(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        host_we_b = 1'b1; host_addr_b = addr; host_wdata_b = data;
        tick();
        host_we_b = 1'b0;
        ref_b[addr] = data;
    endtask

    // Returns data and latency in edges from the AR handshake to the first edge seeing r_valid.
    task automatic read_a(input logic [AW-1:0] addr, input int hold,
                          output logic [DW-1:0] data, output int lat);
        int n;
        n = 0;
        bus_a.ar_valid = 1'b1; bus_a.ar_address = addr;
        while (!bus_a.ar_ready && n < 50) begin tick(); n++; end
        if (n >= 50) check("a_ar_ready_timeout", 32'(bus_a.ar_ready), 32'd1);
        tick();
        bus_a.ar_valid = 1'b0;
        lat = 1;
        while (!bus_a.r_valid && lat < 50) begin tick(); lat++; end
        data = bus_a.r_data;
        check("a_ar_ready_low_in_resp", 32'(bus_a.ar_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            check("a_r_valid_hold", 32'(bus_a.r_valid), 32'd1);
            check("a_r_data_hold", bus_a.r_data, data);
            tick();
        end
        bus_a.r_ready = 1'b1;
        tick();
        bus_a.r_ready = 1'b0;
        check("a_r_valid_drop", 32'(bus_a.r_valid), 32'd0);
        check("a_ar_ready_back", 32'(bus_a.ar_ready), 32'd1);
    endtask

    task automatic read_b(input logic [AW-1:0] addr, output logic [DW-1:0] data, output int lat);
        bus_b.ar_valid = 1'b1; bus_b.ar_address = addr;
        tick();
        bus_b.ar_valid = 1'b0;
        lat = 1;
        while (!bus_b.r_valid && lat < 50) begin tick(); lat++; end
        data = bus_b.r_data;
        bus_b.r_ready = 1'b1;
        tick();
        bus_b.r_ready = 1'b0;
    endtask

    task automatic write_a(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int gap, input bit w_first);
        host_addr_a = addr;
        if (gap == 0) begin
            bus_a.aw_valid = 1'b1; bus_a.aw_address = addr;
            bus_a.w_valid  = 1'b1; bus_a.w_data = data;
            tick();
            bus_a.aw_valid = 1'b0; bus_a.w_valid = 1'b0;
        end else begin
            if (w_first) begin bus_a.w_valid = 1'b1; bus_a.w_data = data; end
            else begin bus_a.aw_valid = 1'b1; bus_a.aw_address = addr; end
            tick();
            bus_a.aw_valid = 1'b0; bus_a.w_valid = 1'b0;
            for (int i = 1; i < gap; i++) begin
                check("a_first_chan_stalled",
                      32'(w_first ? bus_a.w_ready : bus_a.aw_ready), 32'd0);
                tick();
            end
            if (w_first) begin bus_a.aw_valid = 1'b1; bus_a.aw_address = addr; end
            else begin bus_a.w_valid = 1'b1; bus_a.w_data = data; end
            tick();
            bus_a.aw_valid = 1'b0; bus_a.w_valid = 1'b0;
        end
        check("a_busy_before_commit", 32'(busy_a), 32'd1);
        check("a_mem_before_commit", host_rdata_a, ref_a[addr]);
        tick();
        ref_a[addr] = data;
        check("a_mem_after_commit", host_rdata_a, data);
        check("a_busy_after_commit", 32'(busy_a), 32'd0);
        check("a_aw_ready_after_commit", 32'(bus_a.aw_ready), 32'd1);
        check("a_w_ready_after_commit", 32'(bus_a.w_ready), 32'd1);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [DW-1:0] rd;
        int lat;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;

        tbl[0] = '{addr: 4'd3, data: 32'hDEADBEEF, via_bus: 1'b0, gap: 0, w_first: 1'b0, hold: 0, exp: 32'hDEADBEEF};
        tbl[1] = '{addr: 4'd3, data: 32'hDEADBEEF, via_bus: 1'b0, gap: 0, w_first: 1'b0, hold: 5, exp: 32'hDEADBEEF};
        tbl[2] = '{addr: 4'd5, data: 32'h12345678, via_bus: 1'b1, gap: 3, w_first: 1'b0, hold: 0, exp: 32'h12345678};
        tbl[3] = '{addr: 4'd0, data: 32'hA5A5_0F0F, via_bus: 1'b1, gap: 0, w_first: 1'b0, hold: 1, exp: 32'hA5A5_0F0F};
        tbl[4] = '{addr: 4'd15, data: 32'hFFFF_FFFF, via_bus: 1'b1, gap: 2, w_first: 1'b1, hold: 0, exp: 32'hFFFF_FFFF};
        tbl[5] = '{addr: 4'd8, data: 32'h0000_0000, via_bus: 1'b0, gap: 0, w_first: 1'b0, hold: 2, exp: 32'h0000_0000};

        host_we_a = 0; host_addr_a = '0; host_wdata_a = '0;
        host_we_b = 0; host_addr_b = '0; host_wdata_b = '0;
        bus_a.ar_valid = 0; bus_a.ar_address = '0; bus_a.r_ready = 0;
        bus_a.aw_valid = 0; bus_a.aw_address = '0; bus_a.w_valid = 0; bus_a.w_data = '0;
        bus_b.ar_valid = 0; bus_b.ar_address = '0; bus_b.r_ready = 0;
        bus_b.aw_valid = 0; bus_b.aw_address = '0; bus_b.w_valid = 0; bus_b.w_data = '0;

        tick();
        tick();
        check("rst_r_valid", 32'(bus_a.r_valid), 32'd0);
        check("rst_r_data", bus_a.r_data, 32'd0);
        check("rst_ar_ready", 32'(bus_a.ar_ready), 32'd1);
        check("rst_aw_ready", 32'(bus_a.aw_ready), 32'd1);
        check("rst_w_ready", 32'(bus_a.w_ready), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            host_write_a(4'(i), $urandom);
            host_write_b(4'(i), $urandom);
        end

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].via_bus) write_a(tbl[i].addr, tbl[i].data, tbl[i].gap, tbl[i].w_first);
            else host_write_a(tbl[i].addr, tbl[i].data);
            host_addr_a = tbl[i].addr;
            #1;
            check("tbl_host_rdata", host_rdata_a, tbl[i].exp);
            read_a(tbl[i].addr, tbl[i].hold, rd, lat);
            check("tbl_read_data", rd, tbl[i].exp);
            check("tbl_read_latency", 32'(lat), 32'd1);
        end

        // Same-edge read capture and write commit to one address.
        host_write_a(4'd2, 32'h1);
        bus_a.aw_valid = 1'b1; bus_a.aw_address = 4'd2;
        bus_a.w_valid  = 1'b1; bus_a.w_data = 32'h2;
        tick();
        bus_a.aw_valid = 1'b0; bus_a.w_valid = 1'b0;
        bus_a.ar_valid = 1'b1; bus_a.ar_address = 4'd2;
        tick();
        bus_a.ar_valid = 1'b0;
        check("collision_r_valid", 32'(bus_a.r_valid), 32'd1);
        check("collision_old_data", bus_a.r_data, 32'h1);
        bus_a.r_ready = 1'b1;
        tick();
        bus_a.r_ready = 1'b0;
        ref_a[2] = 32'h2;
        read_a(4'd2, 0, rd, lat);
        check("collision_new_data", rd, 32'h2);

        // Host write while a write address sits buffered is dropped.
        bus_a.aw_valid = 1'b1; bus_a.aw_address = 4'd4;
        tick();
        bus_a.aw_valid = 1'b0;
        check("busy_with_aw_only", 32'(busy_a), 32'd1);
        host_write_a(4'd11, 32'h0BAD_0BAD);
        host_addr_a = 4'd11;
        #1;
        check("host_we_dropped", host_rdata_a, ref_a[11]);
        bus_a.w_valid = 1'b1; bus_a.w_data = 32'hCAFE_F00D;
        tick();
        bus_a.w_valid = 1'b0;
        tick();
        ref_a[4] = 32'hCAFE_F00D;
        host_addr_a = 4'd4;
        #1;
        check("late_w_commit", host_rdata_a, 32'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            addr = 4'($urandom_range(0, 15));
            data = $urandom;
            case ($urandom_range(0, 2))
                0: host_write_a(addr, data);
                1: write_a(addr, data, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                default: begin
                    read_a(addr, $urandom_range(0, 3), rd, lat);
                    check("rand_a_read", rd, ref_a[addr]);
                    check("rand_a_latency", 32'(lat), 32'd1);
                end
            endcase
        end

        for (int i = 0; i < 10; i++) begin
            addr = 4'($urandom_range(0, 15));
            read_b(addr, rd, lat);
            check("rand_b_read", rd, ref_b[addr]);
            check("rand_b_latency", 32'(lat), 32'd4);
        end

        // Reset while B waits on a read and holds a buffered write address.
        bus_b.ar_valid = 1'b1; bus_b.ar_address = 4'd7;
        tick();
        bus_b.ar_valid = 1'b0;
        bus_b.aw_valid = 1'b1; bus_b.aw_address = 4'd9;
        tick();
        bus_b.aw_valid = 1'b0;
        check("b_in_wait_busy", 32'(busy_b), 32'd1);
        check("b_in_wait_r_valid", 32'(bus_b.r_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_r_valid", 32'(bus_b.r_valid), 32'd0);
        check("mid_rst_ar_ready", 32'(bus_b.ar_ready), 32'd1);
        check("mid_rst_aw_ready", 32'(bus_b.aw_ready), 32'd1);
        check("mid_rst_w_ready", 32'(bus_b.w_ready), 32'd1);
        check("mid_rst_busy", 32'(busy_b), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", 32'(busy_b), 32'd0);
        host_addr_b = 4'd9;
        #1;
        check("post_rst_mem9", host_rdata_b, ref_b[9]);
        host_addr_b = 4'd7;
        #1;
        check("post_rst_mem7", host_rdata_b, ref_b[7]);
        read_b(4'd7, rd, lat);
        check("post_rst_b_read", rd, ref_b[7]);
        for (int i = 0; i < 4; i++) begin
            addr = 4'($urandom_range(0, 15));
            read_a(addr, 0, rd, lat);
            check("post_rst_a_read", rd, ref_a[addr]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sort_mem_slave.md
Name: sort_mem_slave

Overview:
Word-addressed memory slave that sits directly downstream of sort_circuit and serves its AR/R and AW/W channels. It holds the array being sorted, applies a programmable read latency, and buffers write address and write data independently. A host side-port preloads the array before start and reads back the result after done. There is no write-response channel.

Parameters:
ADDR_WDTH, 4, address width; depth = 2**ADDR_WDTH words.
DATA_WDTH, 32, word width.
RD_LATENCY, 1, cycles from AR handshake edge to r_valid rising; legal range 1..15.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ar_valid  input  1  read address valid
ar_ready  output  1  read address ready
ar_address  input  ADDR_WDTH  read word address
r_valid  output  1  read data valid
r_ready  input  1  read data ready
r_data  output  DATA_WDTH  read data
aw_valid  input  1  write address valid
aw_ready  output  1  write address ready
aw_address  input  ADDR_WDTH  write word address
w_valid  input  1  write data valid
w_ready  output  1  write data ready
w_data  input  DATA_WDTH  write data
host_we  input  1  host write strobe
host_addr  input  ADDR_WDTH  host address
host_wdata  input  DATA_WDTH  host write data
host_rdata  output  DATA_WDTH  combinational mem[host_addr]
busy  output  1  transaction in flight

Behaviour:
- Reset (async, rst_n=0): read FSM to R_IDLE; AW/W buffers empty; r_valid=0, r_data=0, ar_ready=1, aw_ready=1, w_ready=1, busy=0. Memory contents are not reset and survive a reset mid-operation.
- A handshake occurs on a rising edge where valid&&ready are both high.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: ar_ready=1. On an AR handshake, latch ar_address. If RD_LATENCY==1, capture mem[ar_address] into r_data and go to R_RESP. Otherwise load a 4-bit counter with RD_LATENCY-2 and go to R_WAIT.
  - R_WAIT: ar_ready=0. Decrement the counter each cycle. On the edge where the counter is 0, capture mem[latched addr] into r_data and go to R_RESP.
  - R_RESP: r_valid=1. r_data is held stable until the R handshake. On the R handshake, go to R_IDLE; r_valid drops and ar_ready rises on the same edge.
  - Net latency: AR handshake at edge N gives r_valid high from edge N+RD_LATENCY. Back-to-back reads cost RD_LATENCY+1 cycles minimum.
- Write path: two independent one-entry buffers, AW and W.
  - aw_ready = !aw_full; w_ready = !w_full.
  - Address and data may arrive in either order or on the same edge.
  - Commit: on any edge where aw_full && w_full, write mem[aw_buf] = w_buf and clear both buffers. Both readies re-assert after that edge.
  - Net: if both handshakes land on edge N, memory updates at edge N+1. A second AW before its W is stalled (aw_ready=0).
- Read/write collision: if a read capture and a write commit to the same address fall on the same edge, r_data gets the OLD value (read-before-write).
- Host port:
  - host_rdata is combinational and reflects all completed writes.
  - host_we writes on the clock edge only when busy=0. When busy=1, host_we is ignored (the write is dropped).
- busy = (read state != R_IDLE) || aw_full || w_full.
- ADDR_WDTH-wide addressing covers the full depth; no out-of-range case exists. Counter arithmetic is unsigned and never wraps, because loads are ≤13.
- RD_LATENCY outside 1..15 is illegal; the implementation flags it with a simulation-time $error.

Test Plan:
1. Host writes mem[3]=0xDEADBEEF; AR addr 3 accepted at edge N with RD_LATENCY=1 -> r_valid=1 from edge N+1, r_data=0xDEADBEEF, ar_ready=0 until the R handshake.
2. Same as 1 but r_ready held low 5 cycles -> r_valid and r_data stable all 5 cycles; R handshake on the 6th edge; ar_ready=1 the following cycle.
3. AW addr 5 accepted at edge 0, W 0x12345678 accepted at edge 3 -> aw_ready=0 during cycles 1-4; commit at edge 4; host_rdata(addr 5)=0x12345678 from cycle 4 onward; busy=0 after edge 4.
4. mem[2]=0x1; read capture and write commit of 0x2 to addr 2 on the same edge -> r_data=0x1; the next read of addr 2 returns 0x2.
5. RD_LATENCY=4, AR handshake at edge 10 -> r_valid first high after edge 14, not earlier.
6. rst_n pulsed low while in R_WAIT with an AW buffered -> r_valid=0 and ar_ready/aw_ready/w_ready=1 immediately; busy=0; prior memory contents unchanged; the buffered write is discarded. A host_we issued while busy=1 in a separate run leaves memory unchanged.
